// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the operand mux and its output skid stage.
// The next-state function is the single definition of the EMPTY/ONE/TWO occupancy rules.
package mux_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    function automatic state_e next_state(state_e s, logic acc, logic pop);
        case (s)
            ST_EMPTY: return acc ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
                if (acc && !pop)      return ST_TWO;
                else if (pop && !acc) return ST_EMPTY;
                else                  return ST_ONE;
            end
            ST_TWO:   return pop ? ST_ONE : ST_TWO;
            default:  return ST_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/mux_out_skid_if.sv
// Valid/ready word channel carrying a mux data word and the select tag that produced it.
interface mux_out_skid_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 2
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;

    modport master (output valid, output data, output sel, input ready);
    modport slave  (input valid, input data, input sel, output ready);
endinterface

// File: rtl/mux_out_skid_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux_out_skid.sv
// Output stage of the 4:1 operand mux: 2-entry skid buffer with registered in_ready,
// so consumer stalls never reach back combinationally into the mux select logic.
module mux_out_skid
    import mux_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SEL_W = mux_pkg::SEL_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    mux_out_skid_if.slave    in_if,
    mux_out_skid_if.master   out_if,
    output logic [CNT_W-1:0] xfer_count
);

    state_e           state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [SEL_W-1:0] head_sel_q,  head_sel_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;

    logic acc;
    logic pop;

    assign acc = in_if.valid & in_ready_q;
    assign pop = out_valid_q & out_if.ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;

        if (flush) begin
            // Flush wins over both handshakes; an accepted word is dropped here.
            state_d     = ST_EMPTY;
            head_data_d = '0;
            head_sel_d  = '0;
            skid_data_d = '0;
            skid_sel_d  = '0;
        end else begin
            state_d = next_state(state_q, acc, pop);
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        head_data_d = in_if.data;
                        head_sel_d  = in_if.sel;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        head_data_d = in_if.data;
                        head_sel_d  = in_if.sel;
                    end else if (acc) begin
                        skid_data_d = in_if.data;
                        skid_sel_d  = in_if.sel;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_data_d = skid_data_q;
                        head_sel_d  = skid_sel_q;
                    end
                end
                default: ;
            endcase
        end

        // Handshake flags are decoded from the next state so both come straight from flops.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_data_q <= '0;
            head_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = head_data_q;
    assign out_if.sel   = head_sel_q;

    // A pop in a flush cycle still counts; reset inside the counter masks a coincident pop.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .count (xfer_count)
    );

endmodule

// File: tb/tb_mux_out_skid.sv
// Directed bench for mux_out_skid with a FIFO scoreboard of accepted words.
module tb_mux_out_skid;

    localparam int WIDTH = 16;
    localparam int SEL_W = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] xfer_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH+SEL_W-1:0] sb[$];

    mux_out_skid_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) up_if ();
    mux_out_skid_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dn_if ();

    mux_out_skid #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_if      (up_if.slave),
        .out_if     (dn_if.master),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        up_if.valid = v;
        up_if.data  = d;
        up_if.sel   = s;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ov"}, 32'(dn_if.valid), 32'd0);
        chk({tag, "_ir"}, 32'(up_if.ready), 32'd1);
        chk({tag, "_od"}, 32'(dn_if.data), 32'd0);
        chk({tag, "_os"}, 32'(dn_if.sel), 32'd0);
        chk({tag, "_cnt"}, 32'(xfer_count), 32'd0);
    endtask

    // Scoreboard: each pop is checked against the oldest accepted word; then new accepts are queued.
    always @(negedge clk) begin
        logic [WIDTH+SEL_W-1:0] e;
        if (reset) begin
            sb.delete();
        end else begin
            if (dn_if.valid && dn_if.ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_data", 32'(dn_if.data), 32'(e[WIDTH+SEL_W-1:SEL_W]));
                    chk("sb_sel", 32'(dn_if.sel), 32'(e[SEL_W-1:0]));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (up_if.valid && up_if.ready) begin
                sb.push_back({up_if.data, up_if.sel});
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] words [4];
        words[0] = 16'h0010; words[1] = 16'h0011; words[2] = 16'h1100; words[3] = 16'h0000;

        // 1. reset with junk on the input
        reset = 1'b1; flush = 1'b0; dn_if.ready = 1'b0;
        drive(1'b1, 16'hFFFF, 2'd3);
        tick(); tick();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 2'd0);
        chk_idle("rst");

        // 2. streaming, one cycle latency
        dn_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], SEL_W'(i));
            tick();
            chk("str_ov", 32'(dn_if.valid), 32'd1);
            chk("str_od", 32'(dn_if.data), 32'(words[i]));
            chk("str_os", 32'(dn_if.sel), 32'(i));
        end
        drive(1'b0, 16'h0000, 2'd0);
        tick();
        chk("str_empty", 32'(dn_if.valid), 32'd0);
        chk("str_cnt", 32'(xfer_count), 32'd4);

        // 3. stall and skid
        dn_if.ready = 1'b0;
        drive(1'b1, 16'hA5A5, 2'd1);
        tick();
        chk("stl_ir1", 32'(up_if.ready), 32'd1);
        chk("stl_od1", 32'(dn_if.data), 32'hA5A5);
        drive(1'b1, 16'h5A5A, 2'd2);
        tick();
        chk("stl_ir2", 32'(up_if.ready), 32'd0);
        drive(1'b1, 16'h1234, 2'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_ir_held", 32'(up_if.ready), 32'd0);
            chk("stl_od_stable", 32'(dn_if.data), 32'hA5A5);
            chk("stl_os_stable", 32'(dn_if.sel), 32'd1);
        end
        dn_if.ready = 1'b1;
        tick();
        chk("stl_od2", 32'(dn_if.data), 32'h5A5A);
        chk("stl_ir3", 32'(up_if.ready), 32'd1);
        tick();
        chk("stl_od3", 32'(dn_if.data), 32'h1234);
        chk("stl_os3", 32'(dn_if.sel), 32'd3);
        drive(1'b0, 16'h0000, 2'd0);
        tick();
        chk("stl_empty", 32'(dn_if.valid), 32'd0);
        chk("stl_cnt", 32'(xfer_count), 32'd7);

        // 4. accept and pop together in ONE
        dn_if.ready = 1'b0;
        drive(1'b1, 16'h0001, 2'd0);
        tick();
        dn_if.ready = 1'b1;
        drive(1'b1, 16'h0002, 2'd1);
        tick();
        chk("sim_ov", 32'(dn_if.valid), 32'd1);
        chk("sim_od", 32'(dn_if.data), 32'h0002);
        chk("sim_ir", 32'(up_if.ready), 32'd1);
        chk("sim_cnt", 32'(xfer_count), 32'd8);
        drive(1'b0, 16'h0000, 2'd0);
        tick();
        chk("sim_cnt2", 32'(xfer_count), 32'd9);

        // 5a. flush from TWO with a word offered, no pop
        dn_if.ready = 1'b0;
        drive(1'b1, 16'h1111, 2'd1); tick();
        drive(1'b1, 16'h2222, 2'd2); tick();
        chk("fl_two_ir", 32'(up_if.ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 16'hBEEF, 2'd3);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 2'd0);
        chk("fl_ov", 32'(dn_if.valid), 32'd0);
        chk("fl_ir", 32'(up_if.ready), 32'd1);
        chk("fl_od", 32'(dn_if.data), 32'd0);
        chk("fl_cnt", 32'(xfer_count), 32'd9);
        tick();
        chk("fl_ov2", 32'(dn_if.valid), 32'd0);

        // 5b. flush from ONE with accept and pop in the same cycle
        drive(1'b1, 16'h3333, 2'd2); tick();
        flush = 1'b1; dn_if.ready = 1'b1;
        drive(1'b1, 16'hBEEF, 2'd3);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 2'd0);
        chk("flp_ov", 32'(dn_if.valid), 32'd0);
        chk("flp_cnt", 32'(xfer_count), 32'd10);
        tick();
        chk("flp_ov2", 32'(dn_if.valid), 32'd0);
        chk("flp_od", 32'(dn_if.data), 32'd0);

        // 6. saturation over 2^16+3 pops, then reset from TWO
        dn_if.ready = 1'b1;
        for (int i = 0; i < 65539; i++) begin
            drive(1'b1, WIDTH'(i * 7), SEL_W'(i));
            tick();
        end
        drive(1'b0, 16'h0000, 2'd0);
        tick();
        chk("sat_cnt", 32'(xfer_count), 32'h0000FFFF);
        drive(1'b1, 16'h4444, 2'd1); tick();
        drive(1'b0, 16'h0000, 2'd0); tick();
        chk("sat_hold", 32'(xfer_count), 32'h0000FFFF);

        dn_if.ready = 1'b0;
        drive(1'b1, 16'h5555, 2'd1); tick();
        drive(1'b1, 16'h6666, 2'd2); tick();
        chk("mid_two_ir", 32'(up_if.ready), 32'd0);
        reset = 1'b1; dn_if.ready = 1'b1;
        drive(1'b1, 16'hFFFF, 2'd3);
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 2'd0);
        chk_idle("mid_rst");
        tick();
        chk("mid_rst_ov2", 32'(dn_if.valid), 32'd0);
        drive(1'b1, 16'h7777, 2'd2); tick();
        drive(1'b0, 16'h0000, 2'd0); tick();
        chk("post_rst_cnt", 32'(xfer_count), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
